// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD encode/decode datapaths.
package bcd_pkg;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam int unsigned DIGITS_DEF = 4;
  localparam int unsigned BIN_W_DEF  = 14;

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // True when a BIN_W-bit binary field can hold every DIGITS-digit decimal value.
  function automatic bit bin_w_fits(input int unsigned digits, input int unsigned bin_w);
    return (longint'(1) << bin_w) >= longint'(pow10(digits));
  endfunction

  localparam bit BIN_W_OK = bin_w_fits(DIGITS_DEF, BIN_W_DEF);

endpackage

// File: rtl/sub3.sv
// Post-shift correction cell: inverse of the encoder's add-3 cell.
module sub3 (
  input  logic [3:0] digit,
  output logic [3:0] corrected
);

  // Digits that picked up a weight-8 bit from the shift get 3 removed to restore base 10.
  assign corrected = (digit >= 4'd8) ? (digit - 4'd3) : digit;

endmodule

// File: rtl/bcd2bin_seq.sv
// Iterative BCD-to-binary converter (reverse double-dabble), one bit per clock.
module bcd2bin_seq
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = DIGITS_DEF,
  parameter int unsigned BIN_W  = BIN_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic                busy,
  output logic                done,
  output logic [BIN_W-1:0]    bin_out,
  output logic                err
);

  localparam int unsigned BCD_W  = 4 * DIGITS;
  localparam int unsigned WORK_W = BCD_W + BIN_W;
  localparam int unsigned CNT_W  = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LastCount = CNT_W'(BIN_W - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  count_q;
  logic [WORK_W-1:0] work_q;
  logic [WORK_W-1:0] shifted;
  logic [WORK_W-1:0] work_next;
  logic [BCD_W-1:0]  corr;
  logic              bad_digit;

  assign shifted = work_q >> 1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_corr
    sub3 u_sub3 (
      .digit     (shifted[BIN_W + 4*i +: 4]),
      .corrected (corr[4*i +: 4])
    );
  end

  assign work_next = {corr, shifted[BIN_W-1:0]};

  // Flag any input digit outside 0..9.
  always_comb begin
    bad_digit = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  // FSM, counter, working register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      count_q <= '0;
      work_q  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bin_out <= '0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (bad_digit) begin
              // Error result is staged straight into the outputs; no shifting needed.
              bin_out <= '0;
              err     <= 1'b1;
              done    <= 1'b1;
              state_q <= StDone;
            end else begin
              work_q  <= {bcd_in, {BIN_W{1'b0}}};
              count_q <= '0;
              busy    <= 1'b1;
              state_q <= StShift;
            end
          end
        end
        StShift: begin
          work_q  <= work_next;
          count_q <= count_q + 1'b1;
          if (count_q == LastCount) begin
            // Final shift: publish the result so done and bin_out appear together.
            busy    <= 1'b0;
            done    <= 1'b1;
            bin_out <= work_next[BIN_W-1:0];
            err     <= 1'b0;
            state_q <= StDone;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Self-checking bench for bcd2bin_seq against a decimal arithmetic model.
module tb_bcd2bin_seq;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;
  localparam int LAT    = BIN_W + 1;

  logic              clk;
  logic              rst;
  logic              start;
  logic [4*DIGITS-1:0] bcd_in;
  logic              busy;
  logic              done;
  logic [BIN_W-1:0]  bin_out;
  logic              err;

  int n_checks = 0;
  int n_fail   = 0;

  bcd2bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: decimal value of a packed BCD word.
  function automatic int bcd_value(input logic [15:0] b);
    int v;
    v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
    return v;
  endfunction

  function automatic bit bcd_valid(input logic [15:0] b);
    for (int i = 0; i < DIGITS; i++) if (b[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  // Binary-to-BCD encoder model for round-trip vectors.
  function automatic logic [15:0] int_to_bcd(input int v);
    logic [15:0] b;
    int x;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      b[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return b;
  endfunction

  // Issue one start and observe the response (no comparisons here).
  task automatic run_conv(input logic [15:0] v, output int lat, output logic [BIN_W-1:0] b,
                          output logic e, output logic busy_seen, output logic overlap,
                          output logic single);
    @(negedge clk);
    start  = 1'b1;
    bcd_in = v;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; b = '0; e = 1'b0; busy_seen = 1'b0; overlap = 1'b0; single = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
      if (busy && done) overlap = 1'b1;
      if (done) begin
        lat = n;
        b = bin_out;
        e = err;
        break;
      end
    end
    @(negedge clk);
    single = (lat != 0) && !done;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bcd_in = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_checks++;
      if ({busy, done, bin_out, err} !== '0) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: busy=%b done=%b bin=%h err=%b, need all 0",
                 c, busy, done, bin_out, err);
      end
    end
  endtask

  task automatic check_valid(input string name, input logic [15:0] v);
    int lat; logic [BIN_W-1:0] b; logic e, bs, ov, sg;
    int exp_v;
    exp_v = bcd_value(v);
    run_conv(v, lat, b, e, bs, ov, sg);
    n_checks++;
    if (lat !== LAT) begin
      n_fail++; $display("FAIL %s latency: got %0d need %0d", name, lat, LAT);
    end
    n_checks++;
    if (b !== BIN_W'(exp_v) || e !== 1'b0) begin
      n_fail++; $display("FAIL %s value: got %h err=%b need %h err=0", name, b, e, exp_v);
    end
    n_checks++;
    if (!sg || ov) begin
      n_fail++; $display("FAIL %s done_shape: single=%b overlap=%b need 1/0", name, sg, ov);
    end
  endtask

  task automatic test_basic();
    logic [15:0] vecs [3];
    vecs[0] = 16'h0000; vecs[1] = 16'h1234; vecs[2] = 16'h9999;
    for (int i = 0; i < 3; i++) check_valid($sformatf("basic_%h", vecs[i]), vecs[i]);
  endtask

  task automatic test_invalid();
    int lat; logic [BIN_W-1:0] b; logic e, bs, ov, sg;
    run_conv(16'h12A4, lat, b, e, bs, ov, sg);
    n_checks++;
    if (lat !== 1 || e !== 1'b1 || b !== '0) begin
      n_fail++;
      $display("FAIL invalid_digit: lat=%0d err=%b bin=%h need lat=1 err=1 bin=0", lat, e, b);
    end
    n_checks++;
    if (bs !== 1'b0 || !sg) begin
      n_fail++; $display("FAIL invalid_busy: busy_seen=%b single=%b need 0/1", bs, sg);
    end
    check_valid("after_invalid", 16'h0042);
  endtask

  task automatic test_back_to_back();
    int done_at [$];
    logic [BIN_W-1:0] vals [$];
    @(negedge clk);
    start = 1'b1; bcd_in = 16'h0500;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (c == 3) bcd_in = int_to_bcd($urandom_range(0, 9999));
      if (c == 10) bcd_in = 16'h0500;
      if (c == 30) start = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy && done) begin
        n_fail++; $display("FAIL b2b_overlap cycle %0d: busy and done both 1", c);
      end
      if (done) begin
        done_at.push_back(c);
        vals.push_back(bin_out);
      end
    end
    n_checks++;
    if (done_at.size() != 2) begin
      n_fail++; $display("FAIL b2b_count: got %0d done pulses need 2", done_at.size());
    end else begin
      n_checks++;
      if (done_at[1] - done_at[0] != BIN_W + 2 || done_at[0] != LAT) begin
        n_fail++;
        $display("FAIL b2b_spacing: done at %0d,%0d need %0d,%0d", done_at[0], done_at[1],
                 LAT, LAT + BIN_W + 2);
      end
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (vals[i] !== 14'h01F4) begin
          n_fail++; $display("FAIL b2b_value %0d: got %h need 01f4", i, vals[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    dones = 0;
    @(negedge clk);
    start = 1'b1; bcd_in = 16'h8765;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; start = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, done, bin_out, err} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: busy=%b done=%b bin=%h err=%b need all 0",
               busy, done, bin_out, err);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    n_checks++;
    if (dones != 0) begin
      n_fail++; $display("FAIL reset_mid_activity: got %0d active cycles need 0", dones);
    end
    check_valid("after_reset_mid", 16'h0010);
  endtask

  task automatic test_random();
    int lat; logic [BIN_W-1:0] b; logic e, bs, ov, sg;
    logic [15:0] w;
    int v, pos, exp_v;
    bit ok;
    for (int k = 0; k < 1500; k++) begin
      v = $urandom_range(0, 9999);
      w = int_to_bcd(v);
      if (k % 10 == 9) begin
        pos = $urandom_range(0, DIGITS - 1);
        w[4*pos +: 4] = 4'($urandom_range(10, 15));
      end
      ok = bcd_valid(w);
      exp_v = ok ? v : 0;
      run_conv(w, lat, b, e, bs, ov, sg);
      n_checks++;
      if (b !== BIN_W'(exp_v) || e !== !ok || lat !== (ok ? LAT : 1) || !sg || ov) begin
        n_fail++;
        $display("FAIL random %h: bin=%h err=%b lat=%0d single=%b ovl=%b need bin=%h err=%b lat=%0d",
                 w, b, e, lat, sg, ov, exp_v, !ok, ok ? LAT : 1);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bcd_in = '0;
    test_reset();
    test_basic();
    test_invalid();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
